// File: rtl/mmind_round_ctrl.sv
// -----------------------------------------------------------------------------
// mmind_round_ctrl
//   Round controller for the Mastermind datapath. It runs one game at a time:
//   it takes guesses from the input stage together with the exact-match count
//   from the comparator, steps the external 4-bit guess counter, and declares
//   a win or a loss. An optional per-guess timeout forfeits a guess (scored as
//   zero exact matches) when the player stays idle too long.
//
// Parameters
//   MAX_GUESSES    guesses allowed per game (1..15)
//   TIMEOUT_CYCLES PLAY cycles allowed before a guess is forfeited; 0 = off
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        level; starts a game from IDLE, acknowledges WIN/LOSE
//   guess_valid  guess and exact are valid this cycle
//   exact        exact-match count of the presented guess (>4 treated as 4)
//   guess_cnt    current value of the external guess counter
//   guess_ready  controller accepts a guess this cycle (PLAY)
//   cnt_en       increment enable to the guess counter (EVAL)
//   cnt_rst      synchronous clear to the guess counter (IDLE)
//   busy         game in progress (PLAY or EVAL)
//   win / lose   game result, held until start
//   guesses_left MAX_GUESSES - guess_cnt, saturating at 0 (combinational)
//   timeout      one-cycle pulse during the EVAL cycle of a forfeited guess
// -----------------------------------------------------------------------------
module mmind_round_ctrl #(
  parameter int MAX_GUESSES    = 10,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [2:0] exact,
  input  logic [3:0] guess_cnt,
  output logic       guess_ready,
  output logic       cnt_en,
  output logic       cnt_rst,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [3:0] guesses_left,
  output logic       timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_LOSE = 3'd4;

  localparam logic [4:0]  MAX5    = 5'(MAX_GUESSES);
  localparam logic [3:0]  MAX4    = 4'(MAX_GUESSES);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  // Timer value on which the guess is forfeited; unused when TO_EN is 0.
  localparam logic [23:0] TO_LAST = TO_EN ? 24'(TIMEOUT_CYCLES - 1) : 24'd0;

  logic [2:0]  r_state;
  logic [2:0]  r_exact;
  logic [23:0] r_timer;
  logic        r_timeout;

  logic [2:0]  w_state_nxt;
  logic        w_accept;
  logic        w_expire;
  logic [2:0]  w_exact_sat;
  logic [4:0]  w_cnt_inc;

  // Handshake: guess_ready is exactly "state is PLAY", so the accept term
  // only needs the state and guess_valid.
  assign w_accept    = (r_state == S_PLAY) && guess_valid;

  // An accept on the expiry edge wins, hence the !guess_valid term.
  assign w_expire    = TO_EN && (r_state == S_PLAY) && (r_timer == TO_LAST)
                       && !guess_valid;

  assign w_exact_sat = (exact > 3'd4) ? 3'd4 : exact;

  // The counter increments on the edge leaving EVAL, so the decision looks
  // at the value it is about to take. Five bits keep 15+1 from wrapping.
  assign w_cnt_inc   = {1'b0, guess_cnt} + 5'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_PLAY;
      S_PLAY: if (w_accept || w_expire) w_state_nxt = S_EVAL;
      S_EVAL: begin
        if (r_exact == 3'd4)        w_state_nxt = S_WIN;
        else if (w_cnt_inc >= MAX5) w_state_nxt = S_LOSE;
        else                        w_state_nxt = S_PLAY;
      end
      S_WIN:  if (start) w_state_nxt = S_IDLE;
      S_LOSE: if (start) w_state_nxt = S_IDLE;
      default:           w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_exact   <= 3'd0;
      r_timer   <= 24'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_expire;

      if (w_accept)      r_exact <= w_exact_sat;
      else if (w_expire) r_exact <= 3'd0;

      // The timer only runs while waiting in PLAY; every other state parks it
      // at zero, so each entry into PLAY starts a fresh guess window. With the
      // timeout disabled it may wrap, which is harmless.
      if ((r_state == S_PLAY) && !w_accept) r_timer <= r_timer + 24'd1;
      else                                  r_timer <= 24'd0;
    end
  end

  assign guess_ready  = (r_state == S_PLAY);
  assign cnt_en       = (r_state == S_EVAL);
  assign cnt_rst      = (r_state == S_IDLE);
  assign busy         = (r_state == S_PLAY) || (r_state == S_EVAL);
  assign win          = (r_state == S_WIN);
  assign lose         = (r_state == S_LOSE);
  assign timeout      = r_timeout;

  assign guesses_left = (guess_cnt >= MAX4) ? 4'd0 : (MAX4 - guess_cnt);

endmodule
